// File: rtl/hex_msg_rotator.sv
// hex_msg_rotator: holds a six-slot message of 3-bit character codes and
// scrolls it one slot left or right every TICK_COUNT enabled clocks. Each
// code output feeds one combinational code-to-segment decoder for HEX5..HEX0.
module hex_msg_rotator #(
    parameter int          TICK_COUNT = 50000000,
    parameter logic [17:0] MSG        = 18'o543210
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    output logic [2:0] code0,
    output logic [2:0] code1,
    output logic [2:0] code2,
    output logic [2:0] code3,
    output logic [2:0] code4,
    output logic [2:0] code5,
    output logic [2:0] pos,
    output logic       tick
);

    // A single-count step still needs a one-bit counter; it simply stays at 0.
    localparam int             CNT_W   = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);

    // Packed message: slot i lives in bits [3i+2:3i], slot 0 is HEX0.
    logic [17:0]      msg_q, msg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic             tick_q, tick_d;

    // Next-state logic: load beats enable; enable counts and rotates at
    // terminal count; otherwise everything holds and tick drops.
    always_comb begin
        msg_d  = msg_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        if (load) begin
            msg_d = MSG;
            cnt_d = '0;
            pos_d = 3'd0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (!dir) begin
                    // Left: each code moves toward HEX5, code5 wraps into slot 0.
                    msg_d = {msg_q[14:0], msg_q[17:15]};
                    pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
                end else begin
                    // Right: each code moves toward HEX0, code0 wraps into slot 5.
                    msg_d = {msg_q[2:0], msg_q[17:3]};
                    pos_d = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset to the load state.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            msg_q  <= MSG;
            cnt_q  <= '0;
            pos_q  <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            msg_q  <= msg_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

    assign code0 = msg_q[2:0];
    assign code1 = msg_q[5:3];
    assign code2 = msg_q[8:6];
    assign code3 = msg_q[11:9];
    assign code4 = msg_q[14:12];
    assign code5 = msg_q[17:15];
    assign pos   = pos_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_hex_msg_rotator.sv
// Directed bench for hex_msg_rotator: one instance with TICK_COUNT=4 for the
// main scenarios and one with TICK_COUNT=1 for the every-cycle case.
module tb_hex_msg_rotator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, en, dir, load;
    logic [2:0] c0, c1, c2, c3, c4, c5, pos;
    logic       tick;

    logic       resetn_b, en_b, dir_b, load_b;
    logic [2:0] b0, b1, b2, b3, b4, b5, pos_b;
    logic       tick_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Left-rotation sequence of {code5..code0} after n ticks from MSG.
    logic [17:0] left_tab [7] = '{18'o543210, 18'o432105, 18'o321054, 18'o210543,
                                  18'o105432, 18'o054321, 18'o543210};

    hex_msg_rotator #(.TICK_COUNT(4), .MSG(18'o543210)) dut (
        .CLOCK_50(clk), .resetn(resetn), .en(en), .dir(dir), .load(load),
        .code0(c0), .code1(c1), .code2(c2), .code3(c3), .code4(c4), .code5(c5),
        .pos(pos), .tick(tick)
    );

    hex_msg_rotator #(.TICK_COUNT(1), .MSG(18'o543210)) dut_b (
        .CLOCK_50(clk), .resetn(resetn_b), .en(en_b), .dir(dir_b), .load(load_b),
        .code0(b0), .code1(b1), .code2(b2), .code3(b3), .code4(b4), .code5(b5),
        .pos(pos_b), .tick(tick_b)
    );

    function automatic logic [17:0] codes();
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [17:0] codes_b();
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (codes() !== 18'o543210) begin
            n_fail++; $display("FAIL reset_codes got %o exp %o", codes(), 18'o543210);
        end
        n_tests++;
        if (pos !== 3'd0 || tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_pos_tick got pos=%0d tick=%b exp pos=0 tick=0", pos, tick);
        end
    endtask

    task automatic test_rotate_left();
        int ticks = 0;
        int last_tick = 0;
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            n_tests++;
            if (tick !== ((k % 4) == 0)) begin
                n_fail++; $display("FAIL left_tick cyc=%0d got %b exp %b", k, tick, (k % 4) == 0);
            end
            if (tick === 1'b1) begin
                if (ticks > 0 && k - last_tick != 4) begin
                    n_fail++; $display("FAIL left_spacing cyc=%0d got %0d exp 4", k, k - last_tick);
                end
                ticks++;
                last_tick = k;
            end
            n_tests++;
            if (codes() !== left_tab[k / 4] || pos !== 3'((k / 4) % 6)) begin
                n_fail++; $display("FAIL left_state cyc=%0d got %o pos=%0d exp %o pos=%0d",
                                   k, codes(), pos, left_tab[k / 4], (k / 4) % 6);
            end
        end
        n_tests++;
        if (ticks != 6) begin
            n_fail++; $display("FAIL left_tick_count got %0d exp 6", ticks);
        end
        n_tests++;
        if (codes() !== 18'o543210 || pos !== 3'd0) begin
            n_fail++; $display("FAIL left_restore got %o pos=%0d exp 543210 pos=0", codes(), pos);
        end
    endtask

    task automatic test_rotate_right();
        do_reset();
        en = 1'b1; dir = 1'b1;
        repeat (4) step();
        n_tests++;
        if (codes() !== 18'o054321 || pos !== 3'd5 || tick !== 1'b1) begin
            n_fail++; $display("FAIL right_1 got %o pos=%0d tick=%b exp 054321 pos=5 tick=1", codes(), pos, tick);
        end
        repeat (4) step();
        n_tests++;
        if (codes() !== 18'o105432 || pos !== 3'd4) begin
            n_fail++; $display("FAIL right_2 got %o pos=%0d exp 105432 pos=4", codes(), pos);
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        en = 1'b1; dir = 1'b1;
        repeat (3) step();
        dir = 1'b0;
        step();
        n_tests++;
        if (codes() !== 18'o432105 || pos !== 3'd1 || tick !== 1'b1) begin
            n_fail++; $display("FAIL dir_sampled got %o pos=%0d tick=%b exp 432105 pos=1 tick=1", codes(), pos, tick);
        end
    endtask

    task automatic test_pause();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (2) step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_tests++;
            if (tick !== 1'b0 || codes() !== 18'o543210) begin
                n_fail++; $display("FAIL pause_hold cyc=%0d got tick=%b %o exp tick=0 543210", k, tick, codes());
            end
        end
        en = 1'b1;
        step();
        n_tests++;
        if (tick !== 1'b0 || codes() !== 18'o543210) begin
            n_fail++; $display("FAIL pause_resume1 got tick=%b %o exp tick=0 543210", tick, codes());
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || codes() !== 18'o432105 || pos !== 3'd1) begin
            n_fail++; $display("FAIL pause_resume2 got tick=%b %o pos=%0d exp tick=1 432105 pos=1", tick, codes(), pos);
        end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (8) step();
        n_tests++;
        if (codes() !== 18'o321054 || pos !== 3'd2) begin
            n_fail++; $display("FAIL load_pre got %o pos=%0d exp 321054 pos=2", codes(), pos);
        end
        repeat (3) step();
        load = 1'b1;
        step();
        load = 1'b0;
        n_tests++;
        if (tick !== 1'b0 || codes() !== 18'o543210 || pos !== 3'd0) begin
            n_fail++; $display("FAIL load_apply got tick=%b %o pos=%0d exp tick=0 543210 pos=0", tick, codes(), pos);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (tick !== (k == 4)) begin
                n_fail++; $display("FAIL load_next_tick cyc=%0d got %b exp %b", k, tick, k == 4);
            end
        end
        n_tests++;
        if (codes() !== 18'o432105 || pos !== 3'd1) begin
            n_fail++; $display("FAIL load_after got %o pos=%0d exp 432105 pos=1", codes(), pos);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (6) step();
        resetn = 1'b0; load = 1'b1;
        step();
        n_tests++;
        if (tick !== 1'b0 || codes() !== 18'o543210 || pos !== 3'd0) begin
            n_fail++; $display("FAIL reset_mid got tick=%b %o pos=%0d exp tick=0 543210 pos=0", tick, codes(), pos);
        end
        resetn = 1'b1; load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (tick !== (k == 4)) begin
                n_fail++; $display("FAIL reset_mid_tick cyc=%0d got %b exp %b", k, tick, k == 4);
            end
        end
    endtask

    task automatic test_tick_one();
        resetn_b = 1'b0; load_b = 1'b1; en_b = 1'b1; dir_b = 1'b0;
        step();
        n_tests++;
        if (tick_b !== 1'b0 || codes_b() !== 18'o543210 || pos_b !== 3'd0) begin
            n_fail++; $display("FAIL t1_reset got tick=%b %o pos=%0d exp tick=0 543210 pos=0", tick_b, codes_b(), pos_b);
        end
        resetn_b = 1'b1; load_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_tests++;
            if (tick_b !== 1'b1 || codes_b() !== left_tab[k % 6] || pos_b !== 3'(k % 6)) begin
                n_fail++; $display("FAIL t1_rotate cyc=%0d got tick=%b %o pos=%0d exp tick=1 %o pos=%0d",
                                   k, tick_b, codes_b(), pos_b, left_tab[k % 6], k % 6);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
        resetn_b = 1'b0; en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0;
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_dir_change();
        test_pause();
        test_load();
        test_reset_mid();
        test_tick_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
